// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and issues one instruction-memory read at a time to feed IF/ID.
// Ports: clk/rst (sync, active-high); stall_d/stall_m hold the PC; branchTaken/branch_target redirect;
// imem_rd/imem_addr request, imem_data/imem_done/imem_err response; instr_f/pc_f/stall_f to IF/ID;
// err_instr_mem flags a misaligned PC or memory error for one cycle.
module fetch_stage #(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        stall_m,
  input  logic        branchTaken,
  input  logic [15:0] branch_target,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic [15:0] instr_f,
  output logic [15:0] pc_f,
  output logic        stall_f,
  output logic        err_instr_mem
);
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, tgt_q, tgt_d;
  logic        active, mis, valid, hold, halt_op;
  always_comb begin
    active        = !rst && (state_q == FETCH || state_q == WAIT);
    mis           = active && pc_q[0];
    valid         = active && !pc_q[0] && imem_done;
    hold          = stall_d || stall_m;
    halt_op       = imem_data[15:11] == 5'd0 || imem_err;
    imem_rd       = !rst && ((active && !pc_q[0]) || state_q == DRAIN);
    imem_addr     = pc_q;
    pc_f          = pc_q + 16'd2;
    instr_f       = mis ? 16'h0000 : valid ? imem_data : NOP_INSTR;
    stall_f       = !(mis || valid);
    err_instr_mem = mis || (valid && imem_err);
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    case (state_q)
      FETCH, WAIT:
        if (branchTaken && (pc_q[0] || imem_done)) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (pc_q[0]) state_d = HALTED;
        else if (!imem_done) begin
          // a redirect while the read is in flight must wait for the response to drain
          state_d = branchTaken ? DRAIN : WAIT;
          tgt_d   = branchTaken ? branch_target : tgt_q;
        end else if (!hold) begin
          pc_d    = pc_q + 16'd2;
          state_d = halt_op ? HALTED : FETCH;
        end else state_d = FETCH;
      DRAIN: begin
        tgt_d = branchTaken ? branch_target : tgt_q;
        if (imem_done) begin
          pc_d    = tgt_d;
          state_d = FETCH;
        end
      end
      HALTED:
        if (branchTaken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then random traffic against a behavioural fetch model.
module tb_fetch_stage;
  logic        clk = 0, rst, stall_d, stall_m, branchTaken, imem_done, imem_err;
  logic [15:0] branch_target, imem_data;
  logic        imem_rd, stall_f, err_instr_mem;
  logic [15:0] imem_addr, instr_f, pc_f;
  int          errors = 0, checks = 0;
  logic [15:0] m_pc, m_tgt;
  bit          m_halt, m_drain;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .stall_m(stall_m), .branchTaken(branchTaken),
    .branch_target(branch_target), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_done(imem_done), .imem_err(imem_err), .instr_f(instr_f),
    .pc_f(pc_f), .stall_f(stall_f), .err_instr_mem(err_instr_mem)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit r, sd, sm, br, input logic [15:0] bt, input bit dn,
                       input logic [15:0] dat, input bit er);
    logic e_rd, e_stall, e_err;
    logic [15:0] e_instr;
    rst = r; stall_d = sd; stall_m = sm; branchTaken = br; branch_target = bt;
    imem_done = dn; imem_data = dat; imem_err = er;
    #2;
    e_rd = 0; e_stall = 1; e_err = 0; e_instr = 16'h0800;
    if (!r && !m_halt && m_drain) e_rd = 1;
    else if (!r && !m_halt && m_pc[0]) begin e_err = 1; e_instr = 16'h0000; e_stall = 0; end
    else if (!r && !m_halt) begin
      e_rd = 1;
      if (dn) begin e_instr = dat; e_stall = 0; e_err = er; end
    end
    check("imem_rd", {15'd0, imem_rd}, {15'd0, e_rd});
    if (e_rd) check("imem_addr", imem_addr, m_pc);
    check("instr_f", instr_f, e_instr);
    check("stall_f", {15'd0, stall_f}, {15'd0, e_stall});
    check("err_instr_mem", {15'd0, err_instr_mem}, {15'd0, e_err});
    check("pc_f", pc_f, m_pc + 16'd2);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin m_pc = 16'h0000; m_halt = 0; m_drain = 0; m_tgt = 0; end
    else if (m_halt) begin if (branchTaken) begin m_pc = branch_target; m_halt = 0; end end
    else if (m_drain) begin
      if (branchTaken) m_tgt = branch_target;
      if (imem_done) begin m_pc = m_tgt; m_drain = 0; end
    end else if (m_pc[0]) begin if (branchTaken) m_pc = branch_target; else m_halt = 1; end
    else if (imem_done) begin
      if (branchTaken) m_pc = branch_target;
      else if (!(stall_d || stall_m)) begin
        m_pc = m_pc + 16'd2;
        if (imem_data[15:11] == 5'd0 || imem_err) m_halt = 1;
      end
    end else if (branchTaken) begin m_tgt = branch_target; m_drain = 1; end
    @(negedge clk);
  endtask
  initial begin
    m_pc = 0; m_tgt = 0; m_halt = 0; m_drain = 0;
    @(negedge clk);
    rst = 1; stall_d = 0; stall_m = 0; branchTaken = 0; branch_target = 0;
    imem_done = 0; imem_data = 0; imem_err = 0;
    tick();
    drive(1, 0, 0, 0, 0, 1, 16'h4001, 0);
    check("rst_rd", {15'd0, imem_rd}, 16'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 16'h4001, 0);
      check("t1_addr", imem_addr, 16'(2 * i));
      check("t1_pcf", pc_f, 16'(2 * i + 2));
      tick();
    end
    drive(0, 0, 0, 1, 16'h0010, 1, 16'h4001, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 16'h1234, 0);
      check("t2_addr", imem_addr, 16'h0010);
      check("t2_nop", instr_f, 16'h0800);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 16'h1234, 0);
    check("t2_data", instr_f, 16'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_next", imem_addr, 16'h0012);
    drive(0, 0, 0, 1, 16'h0020, 1, 16'h4001, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 16'hBEEF, 0); tick();
    drive(0, 0, 0, 1, 16'h0100, 0, 16'hBEEF, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 16'hBEEF, 0);
    check("t3_drain_stall", {15'd0, stall_f}, 16'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_redirect", imem_addr, 16'h0100);
    drive(0, 0, 0, 1, 16'h0008, 1, 16'h4001, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, i < 2, 0, 0, 0, 1, 16'h4001, 0);
      check("t4_addr", imem_addr, 16'h0008);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_next", imem_addr, 16'h000A);
    drive(0, 0, 0, 1, 16'h0030, 1, 16'h4001, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 16'h0000, 0);
    check("t5_halt_instr", instr_f, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 1, 16'h4001, 0);
    check("t5_halted_rd", {15'd0, imem_rd}, 16'd0);
    tick();
    drive(0, 0, 0, 1, 16'h0040, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_resume", imem_addr, 16'h0040);
    drive(0, 0, 0, 1, 16'h0041, 1, 16'h4001, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 16'h4001, 0);
    check("t6_err", {15'd0, err_instr_mem}, 16'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 16'h4001, 0); tick();
    drive(0, 0, 0, 1, 16'h0050, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 16'h4001, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_rst_addr", imem_addr, 16'h0000);
    tick();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] bt;
      bt = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(15) == 0) bt[0] = 1'b1;
      drive($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0, bt, $urandom_range(1) == 1, 16'($urandom),
            $urandom_range(15) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
